// File: rtl/ysyx_22050243_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch into a small {pc, inst} buffer.
// A redirect flushes the buffer and drops the responses of every request still outstanding.

module ysyx_22050243_ifu_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic          clk,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] cnt
);
  // The credit rule makes a push into a full buffer impossible; trap it if that ever breaks
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      assert (cnt != CW'(DEPTH)) else $fatal(1, "ifu instruction buffer overflow");
    end
  end
endmodule

module ysyx_22050243_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int DW  = CW + 4;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = CW1'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    if (p == LAST_IDX) n = {AW{1'b0}};
    else               n = p + AW'(1'b1);
    return n;
  endfunction

  logic [63:0]   pc_r;
  logic [CW-1:0] in_flight_r;
  logic [DW-1:0] drop_r;
  logic [63:0]   iss_pc_r [DEPTH];
  logic [AW-1:0] iss_rd_r;
  logic [AW-1:0] iss_wr_r;
  logic [63:0]   buf_pc_r   [DEPTH];
  logic [31:0]   buf_inst_r [DEPTH];
  logic [AW-1:0] buf_rd_r;
  logic [AW-1:0] buf_wr_r;
  logic [CW-1:0] buf_cnt_r;

  logic          credit_s;
  logic          issue_s;
  logic          rsp_keep_s;
  logic          push_s;
  logic          pop_s;
  logic [63:0]   redirect_pc_s;

  // Drop counter only counts responses of abandoned requests, so it is not part of the credit
  assign credit_s      = ({1'b0, in_flight_r} + {1'b0, buf_cnt_r}) < DEPTH_C;
  assign req_valid     = rst && !redirect_valid && credit_s;
  assign req_addr      = pc_r;
  assign issue_s       = req_valid && req_ready;
  assign rsp_keep_s    = rsp_valid && (drop_r == {DW{1'b0}});
  assign push_s        = rsp_keep_s && !redirect_valid;
  assign inst_valid    = (buf_cnt_r != {CW{1'b0}});
  assign pop_s         = inst_valid && inst_ready && !redirect_valid;
  assign inst          = buf_inst_r[buf_rd_r];
  assign inst_pc       = buf_pc_r[buf_rd_r];
  assign redirect_pc_s = redirect_pc & ~64'd3;

  // Fetch PC and request accounting; a redirect turns every outstanding request into a drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r        <= RESET_PC;
      in_flight_r <= {CW{1'b0}};
      drop_r      <= {DW{1'b0}};
    end else if (redirect_valid) begin
      pc_r        <= redirect_pc_s;
      in_flight_r <= {CW{1'b0}};
      drop_r      <= drop_r + DW'(in_flight_r) - DW'(rsp_valid);
    end else begin
      if (issue_s) pc_r <= pc_r + 64'd4;
      in_flight_r <= in_flight_r + CW'(issue_s) - CW'(rsp_keep_s);
      drop_r      <= drop_r - DW'(rsp_valid && !rsp_keep_s);
    end
  end

  // Addresses of live in-flight requests, consumed in order by kept responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) iss_pc_r[i] <= 64'd0;
      iss_rd_r <= {AW{1'b0}};
      iss_wr_r <= {AW{1'b0}};
    end else if (redirect_valid) begin
      iss_rd_r <= {AW{1'b0}};
      iss_wr_r <= {AW{1'b0}};
    end else begin
      if (issue_s) begin
        iss_pc_r[iss_wr_r] <= pc_r;
        iss_wr_r           <= ptr_inc(iss_wr_r);
      end
      if (rsp_keep_s) iss_rd_r <= ptr_inc(iss_rd_r);
    end
  end

  // Instruction buffer; entries are registers so decode never sees rsp_data combinationally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_r[i]   <= 64'd0;
        buf_inst_r[i] <= 32'd0;
      end
      buf_rd_r  <= {AW{1'b0}};
      buf_wr_r  <= {AW{1'b0}};
      buf_cnt_r <= {CW{1'b0}};
    end else if (redirect_valid) begin
      buf_rd_r  <= {AW{1'b0}};
      buf_wr_r  <= {AW{1'b0}};
      buf_cnt_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        buf_pc_r[buf_wr_r]   <= iss_pc_r[iss_rd_r];
        buf_inst_r[buf_wr_r] <= rsp_data;
        buf_wr_r             <= ptr_inc(buf_wr_r);
      end
      if (pop_s) buf_rd_r <= ptr_inc(buf_rd_r);
      buf_cnt_r <= buf_cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  ysyx_22050243_ifu_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk  (clk),
    .push (push_s),
    .pop  (pop_s),
    .cnt  (buf_cnt_r)
  );

endmodule
